// File: rtl/bs_decoder.sv
// rtl/bs_decoder.sv - USB receive bitstream decoder: SYNC hunt, PID classify, SIPO packet hold
module bs_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_in,
    input  logic        s_valid,
    input  logic        eop,
    input  logic        pkt_taken,
    output logic        pkt_avail,
    output logic [1:0]  pkt_type,
    output logic [87:0] data,
    output logic [23:0] token,
    output logic [7:0]  hshake,
    output logic        pkt_err,
    output logic        free_outbound
);

    // Bit counts after SYNC; the counter runs across PID and body.
    localparam logic [6:0] DATA_BITS   = 7'd88;
    localparam logic [6:0] TOKEN_BITS  = 7'd24;
    localparam logic [6:0] HSHAKE_BITS = 7'd8;
    localparam logic [7:0] SYNC_PAT    = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC_HUNT,
        S_PID,
        S_BODY,
        S_EOP_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [87:0] r_sipo,  w_sipo_nxt;
    logic [7:0]  r_win,   w_win_nxt;
    logic [6:0]  r_cnt,   w_cnt_nxt;
    logic [6:0]  r_len,   w_len_nxt;
    logic [1:0]  r_type,  w_type_nxt;

    // eop wins over a coincident bit, so such a bit is never accepted.
    logic        w_bit;
    logic [87:0] w_sipo_shift;
    logic [7:0]  w_win_shift;
    logic [7:0]  w_pid;
    logic        w_pid_ok;
    logic [6:0]  w_cnt_inc;

    assign w_bit        = s_valid & ~eop;
    assign w_sipo_shift = {r_sipo[86:0], s_in};
    assign w_win_shift  = {r_win[6:0], s_in};
    assign w_pid        = w_sipo_shift[7:0];
    assign w_pid_ok     = (w_pid[7:4] == ~w_pid[3:0]);
    assign w_cnt_inc    = r_cnt + 7'd1;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sipo  <= '0;
            r_win   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_type  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_sipo  <= w_sipo_nxt;
            r_win   <= w_win_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_type  <= w_type_nxt;
        end
    end

    // Next-state and datapath update; HOLD leaves everything frozen
    always_comb begin
        w_state_nxt = r_state;
        w_sipo_nxt  = r_sipo;
        w_win_nxt   = r_win;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_type_nxt  = r_type;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_SYNC_HUNT;
            end
            S_SYNC_HUNT: begin
                if (w_bit) begin
                    w_win_nxt = w_win_shift;
                    if (w_win_shift == SYNC_PAT) begin
                        w_state_nxt = S_PID;
                        w_cnt_nxt   = '0;
                        w_sipo_nxt  = '0;
                    end
                end
            end
            S_PID: begin
                if (eop) begin
                    w_state_nxt = S_ERR;
                end else if (s_valid) begin
                    w_sipo_nxt = w_sipo_shift;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == HSHAKE_BITS) begin
                        if (!w_pid_ok) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            case (w_pid[1:0])
                                2'b01: begin
                                    w_type_nxt  = 2'b01;
                                    w_len_nxt   = TOKEN_BITS;
                                    w_state_nxt = S_BODY;
                                end
                                2'b11: begin
                                    w_type_nxt  = 2'b00;
                                    w_len_nxt   = DATA_BITS;
                                    w_state_nxt = S_BODY;
                                end
                                2'b10: begin
                                    w_type_nxt  = 2'b10;
                                    w_len_nxt   = HSHAKE_BITS;
                                    w_state_nxt = S_EOP_WAIT;
                                end
                                default: w_state_nxt = S_ERR;
                            endcase
                        end
                    end
                end
            end
            S_BODY: begin
                if (eop) begin
                    w_state_nxt = S_ERR;
                end else if (s_valid) begin
                    w_sipo_nxt = w_sipo_shift;
                    w_cnt_nxt  = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_EOP_WAIT;
                    end
                end
            end
            S_EOP_WAIT: begin
                // Counter stops at the packet length; an extra bit is the overrun.
                if (eop) begin
                    w_state_nxt = S_HOLD;
                end else if (s_valid) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_HOLD: begin
                if (pkt_taken) begin
                    w_state_nxt = S_SYNC_HUNT;
                    w_win_nxt   = '0;
                end
            end
            S_ERR: begin
                w_state_nxt = S_SYNC_HUNT;
                w_win_nxt   = '0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign pkt_avail = (r_state == S_HOLD);
    assign pkt_err   = (r_state == S_ERR);
    assign pkt_type  = r_type;
    assign data      = r_sipo;
    assign token     = r_sipo[23:0];
    assign hshake    = r_sipo[7:0];
    // IDLE counts as free only once reset is released, so it reads 0 during reset.
    assign free_outbound = (r_state == S_SYNC_HUNT) | ((r_state == S_IDLE) & rst_n);

endmodule

// File: tb/tb_bs_decoder.sv
// tb/tb_bs_decoder.sv - directed self-checking bench for bs_decoder
module tb_bs_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_in;
    logic        s_valid;
    logic        eop;
    logic        pkt_taken;
    logic        pkt_avail;
    logic [1:0]  pkt_type;
    logic [87:0] data;
    logic [23:0] token;
    logic [7:0]  hshake;
    logic        pkt_err;
    logic        free_outbound;

    int n_cmp = 0;
    int n_err = 0;
    int err_seen = 0;

    bs_decoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_in          (s_in),
        .s_valid       (s_valid),
        .eop           (eop),
        .pkt_taken     (pkt_taken),
        .pkt_avail     (pkt_avail),
        .pkt_type      (pkt_type),
        .data          (data),
        .token         (token),
        .hshake        (hshake),
        .pkt_err       (pkt_err),
        .free_outbound (free_outbound)
    );

    always #5 clk = ~clk;

    // pkt_err is a level per cycle; sampling mid-cycle counts each pulse once
    always @(negedge clk) if (pkt_err === 1'b1) err_seen++;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_in    = b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [87:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_bits_gap(input logic [87:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) begin
                s_in = 1'($urandom);
                tick();
            end
            send_bit(v[i]);
        end
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    task automatic take();
        pkt_taken = 1'b1;
        tick();
        pkt_taken = 1'b0;
    endtask

    initial begin
        int errs_before;
        rst_n = 1'b0; s_in = 1'b0; s_valid = 1'b0; eop = 1'b0; pkt_taken = 1'b0;
        #3;
        chk("rst_avail", 88'(pkt_avail), 88'd0);
        chk("rst_type", 88'(pkt_type), 88'd0);
        chk("rst_data", data, 88'd0);
        chk("rst_token", 88'(token), 88'd0);
        chk("rst_hshake", 88'(hshake), 88'd0);
        chk("rst_err", 88'(pkt_err), 88'd0);
        chk("rst_free", 88'(free_outbound), 88'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("free_after_release", 88'(free_outbound), 88'd1);
        tick();
        chk("free_sync_hunt", 88'(free_outbound), 88'd1);

        // Handshake ACK
        send_bits(88'h01, 8);
        chk("sync_to_pid_free", 88'(free_outbound), 88'd0);
        send_bits(88'hD2, 8);
        chk("ack_not_yet", 88'(pkt_avail), 88'd0);
        send_eop();
        chk("ack_avail", 88'(pkt_avail), 88'd1);
        chk("ack_type", 88'(pkt_type), 88'd2);
        chk("ack_hshake", 88'(hshake), 88'hD2);
        tick(); tick(); tick();
        chk("ack_still_held", 88'(pkt_avail), 88'd1);
        take();
        chk("ack_dropped", 88'(pkt_avail), 88'd0);
        chk("ack_free", 88'(free_outbound), 88'd1);

        // Token OUT, contiguous then with idle gaps
        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 0) begin
                send_bits(88'h01, 8);
                send_bits(88'hE1, 8);
                send_bits(88'h0A5F, 16);
            end else begin
                send_bits_gap(88'h01, 8);
                send_bits_gap(88'hE1, 8);
                send_bits_gap(88'h0A5F, 16);
            end
            send_eop();
            chk("tok_avail", 88'(pkt_avail), 88'd1);
            chk("tok_type", 88'(pkt_type), 88'd1);
            chk("tok_token", 88'(token), 88'hE10A5F);
            take();
        end

        // Data DATA0, plus a second packet sent while held
        send_bits(88'h01, 8);
        send_bits(88'hC3, 8);
        send_bits(88'h0123_4567_89AB_CDEF, 64);
        send_bits(88'hBEEF, 16);
        send_eop();
        chk("dat_avail", 88'(pkt_avail), 88'd1);
        chk("dat_type", 88'(pkt_type), 88'd0);
        chk("dat_data", data, {8'hC3, 64'h0123_4567_89AB_CDEF, 16'hBEEF});
        errs_before = err_seen;
        send_bits(88'h01, 8);
        send_bits(88'hD2, 8);
        send_eop();
        chk("hold_avail", 88'(pkt_avail), 88'd1);
        chk("hold_type", 88'(pkt_type), 88'd0);
        chk("hold_data", data, {8'hC3, 64'h0123_4567_89AB_CDEF, 16'hBEEF});
        chk("hold_no_err", 88'(err_seen), 88'(errs_before));
        take();
        chk("dat_dropped", 88'(pkt_avail), 88'd0);

        // Bad PID then a good ACK
        send_bits(88'h01, 8);
        send_bits(88'hD3, 8);
        chk("badpid_err", 88'(pkt_err), 88'd1);
        chk("badpid_avail", 88'(pkt_avail), 88'd0);
        tick();
        chk("badpid_err_1cyc", 88'(pkt_err), 88'd0);
        send_bits(88'h01, 8);
        send_bits(88'hD2, 8);
        send_eop();
        chk("after_bad_avail", 88'(pkt_avail), 88'd1);
        chk("after_bad_hshake", 88'(hshake), 88'hD2);
        take();

        // Short token
        send_bits(88'h01, 8);
        send_bits(88'hE1, 8);
        send_bits(88'h0A5, 12);
        send_eop();
        chk("short_tok_err", 88'(pkt_err), 88'd1);
        tick();

        // Handshake overrun
        send_bits(88'h01, 8);
        send_bits(88'hD2, 8);
        send_bit(1'b1);
        chk("long_hs_err", 88'(pkt_err), 88'd1);
        tick();

        // eop together with the last token bit
        send_bits(88'h01, 8);
        send_bits(88'hE1, 8);
        send_bits(88'h052F, 15);
        s_in = 1'b1; s_valid = 1'b1; eop = 1'b1;
        tick();
        s_valid = 1'b0; eop = 1'b0;
        chk("eop_bit_err", 88'(pkt_err), 88'd1);
        chk("eop_bit_avail", 88'(pkt_avail), 88'd0);
        tick();
        chk("err_pulse_count", 88'(err_seen), 88'd4);

        // Reset in the middle of a data body
        send_bits(88'h01, 8);
        send_bits(88'hC3, 8);
        send_bits(88'h0123_4567, 30);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_data", data, 88'd0);
        chk("midrst_type", 88'(pkt_type), 88'd0);
        chk("midrst_err", 88'(pkt_err), 88'd0);
        chk("midrst_free", 88'(free_outbound), 88'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_no_err", 88'(err_seen), 88'd4);
        send_bits(88'h01, 8);
        send_bits(88'hD2, 8);
        send_eop();
        chk("midrst_ack_avail", 88'(pkt_avail), 88'd1);
        chk("midrst_ack_type", 88'(pkt_type), 88'd2);
        chk("midrst_ack_hshake", 88'(hshake), 88'hD2);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
